// File: rtl/div_64b_pkg.sv
// Shared definitions for the RV64 M-extension multiply/divide units:
// FSM encoding, datapath width, latency and RISC-V special-case constants.
package div_64b_pkg;

    localparam int DIV_WIDTH   = 64;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;
    localparam int CNT_W       = $clog2(DIV_WIDTH);

    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DIV_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] MIN_INT   = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_64b_if.sv
// Start/done request bundle shared with the multiplier; the execute stage
// drives the master side, the divider sits on the slave side.
interface div_64b_if import div_64b_pkg::*; ();
    logic                 start;
    logic                 is_signed;
    logic [DIV_WIDTH-1:0] a;
    logic [DIV_WIDTH-1:0] b;
    logic                 busy;
    logic                 done;
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] r;

    modport master (output start, is_signed, a, b, input busy, done, q, r);
    modport slave  (input start, is_signed, a, b, output busy, done, q, r);
endinterface

// File: rtl/div_64b_cu.sv
// Divider control: sequencing FSM, iteration counter and registered
// busy/done handshake outputs.
module div_64b_cu import div_64b_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic load_o,
    output logic prep_o,
    output logic iter_o,
    output logic fix_o,
    output logic busy_o,
    output logic done_o
);
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, counter and datapath strobes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_o  = 1'b0;
        prep_o  = 1'b0;
        iter_o  = 1'b0;
        fix_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    state_d = ST_PREP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                prep_o  = 1'b1;
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_ITER;
            end
            ST_ITER: begin
                iter_o = 1'b1;
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_FIX: begin
                fix_o   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_PREP) || (state_d == ST_ITER) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: rtl/div_64b_dp.sv
// Divider datapath: operand capture, sign stripping, restoring
// shift-subtract step and RISC-V result fixup into held q/r registers.
module div_64b_dp import div_64b_pkg::*; (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 prep_i,
    input  logic                 iter_i,
    input  logic                 fix_i,
    input  logic                 is_signed_i,
    input  logic [DIV_WIDTH-1:0] a_i,
    input  logic [DIV_WIDTH-1:0] b_i,
    output logic [DIV_WIDTH-1:0] q_o,
    output logic [DIV_WIDTH-1:0] r_o
);
    localparam logic [DIV_WIDTH-1:0] ZERO = {DIV_WIDTH{1'b0}};

    logic [DIV_WIDTH-1:0] a_q, b_q, dvd_q, abs_b_q, rem_q, q_res_q, r_res_q;
    logic                 sgn_q, negq_q, negr_q, div0_q, ovf_q;
    logic [DIV_WIDTH-1:0] abs_a_s, abs_b_s, rem_d_s, q_fix_s, r_fix_s;
    logic [DIV_WIDTH:0]   rem_sh_s, trial_s;

    // Sign stripping, trial subtraction and result fixup
    always_comb begin
        abs_a_s  = (sgn_q && a_q[DIV_WIDTH-1]) ? (ZERO - a_q) : a_q;
        abs_b_s  = (sgn_q && b_q[DIV_WIDTH-1]) ? (ZERO - b_q) : b_q;
        rem_sh_s = {rem_q, dvd_q[DIV_WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, abs_b_q};
        // The partial remainder stays below the divisor, so it fits WIDTH bits.
        rem_d_s  = trial_s[DIV_WIDTH] ? rem_sh_s[DIV_WIDTH-1:0] : trial_s[DIV_WIDTH-1:0];
        if (div0_q) begin
            q_fix_s = DIV0_QUOT;
            r_fix_s = a_q;
        end else if (ovf_q) begin
            q_fix_s = a_q;
            r_fix_s = ZERO;
        end else begin
            q_fix_s = negq_q ? (ZERO - dvd_q) : dvd_q;
            r_fix_s = negr_q ? (ZERO - rem_q) : rem_q;
        end
    end

    // Operand capture, preprocessing and iteration; quotient shifts into dvd_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= ZERO;
            b_q     <= ZERO;
            sgn_q   <= 1'b0;
            dvd_q   <= ZERO;
            abs_b_q <= ZERO;
            rem_q   <= ZERO;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            sgn_q <= is_signed_i;
        end else if (prep_i) begin
            dvd_q   <= abs_a_s;
            abs_b_q <= abs_b_s;
            rem_q   <= ZERO;
            negq_q  <= sgn_q && (a_q[DIV_WIDTH-1] ^ b_q[DIV_WIDTH-1]) && (b_q != ZERO);
            negr_q  <= sgn_q && a_q[DIV_WIDTH-1];
            div0_q  <= (b_q == ZERO);
            ovf_q   <= sgn_q && (a_q == MIN_INT) && (b_q == DIV0_QUOT);
        end else if (iter_i) begin
            dvd_q <= {dvd_q[DIV_WIDTH-2:0], ~trial_s[DIV_WIDTH]};
            rem_q <= rem_d_s;
        end
    end

    // Result registers, only touched in FIX so they hold steady during ITER
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_res_q <= ZERO;
            r_res_q <= ZERO;
        end else if (fix_i) begin
            q_res_q <= q_fix_s;
            r_res_q <= r_fix_s;
        end
    end

    assign q_o = q_res_q;
    assign r_o = r_res_q;
endmodule

// File: rtl/div_64b.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU); thin top that
// joins the control unit and datapath to the start/done bus.
module div_64b import div_64b_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    div_64b_if.slave   dbus
);
    logic load_s, prep_s, iter_s, fix_s;

    div_64b_cu u_cu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (dbus.start),
        .load_o  (load_s),
        .prep_o  (prep_s),
        .iter_o  (iter_s),
        .fix_o   (fix_s),
        .busy_o  (dbus.busy),
        .done_o  (dbus.done)
    );

    div_64b_dp u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_s),
        .prep_i      (prep_s),
        .iter_i      (iter_s),
        .fix_i       (fix_s),
        .is_signed_i (dbus.is_signed),
        .a_i         (dbus.a),
        .b_i         (dbus.b),
        .q_o         (dbus.q),
        .r_o         (dbus.r)
    );
endmodule
